// File: rtl/trimmed_mean5_filter_pkg.sv
// Shared definitions for the trimmed-mean filter: FSM states, sort/collect limits
// and the reciprocal constant used for the exact divide-by-three.
package trimmed_mean5_filter_pkg;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_SORT    = 2'd1,
      ST_OUTPUT  = 2'd2
   } state_t;

   localparam logic [2:0] LAST_SLOT  = 3'd4;
   localparam logic [2:0] LAST_PHASE = 3'd4;

   // floor(sum/3) == (sum*683)>>11 for every sum in 0..765
   localparam int DIV3_MUL   = 683;
   localparam int DIV3_SHIFT = 11;

endpackage

// File: rtl/trimmed_mean5_filter_cmp_swap.sv
// Combinational compare-exchange element; equal inputs pass through unswapped
// so the sorting network stays stable.
module trimmed_mean5_filter_cmp_swap #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] lo,
   output logic [DATA_W-1:0] hi
);

   logic swap;

   assign swap = (a > b);
   assign lo   = swap ? b : a;
   assign hi   = swap ? a : b;

endmodule

// File: rtl/trimmed_mean5_filter.sv
// Collects groups of five samples, sorts them with a 5-phase odd-even
// transposition network and registers the middle three plus their floor mean.
module trimmed_mean5_filter
   import trimmed_mean5_filter_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   output logic              busy,
   output logic              dropped,
   output logic              out_valid,
   output logic [DATA_W-1:0] mid1,
   output logic [DATA_W-1:0] mid2,
   output logic [DATA_W-1:0] mid3,
   output logic [DATA_W-1:0] mean
);

   localparam int SUM_W  = DATA_W + 2;
   localparam int PROD_W = SUM_W + DIV3_SHIFT;

   state_t            state_q, state_d;
   logic [2:0]        count_q, count_d;
   logic [2:0]        phase_q, phase_d;
   logic [DATA_W-1:0] win_q [5];
   logic [DATA_W-1:0] win_d [5];
   logic              busy_q, busy_d;
   logic              dropped_q, dropped_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] mid1_q, mid1_d;
   logic [DATA_W-1:0] mid2_q, mid2_d;
   logic [DATA_W-1:0] mid3_q, mid3_d;
   logic [DATA_W-1:0] mean_q, mean_d;

   logic [DATA_W-1:0] lo_01, hi_01, lo_23, hi_23;
   logic [DATA_W-1:0] lo_12, hi_12, lo_34, hi_34;
   logic [SUM_W-1:0]  sum;
   logic [PROD_W-1:0] product;

   // Even-phase pairs (0,1),(2,3) and odd-phase pairs (1,2),(3,4)
   trimmed_mean5_filter_cmp_swap #(.DATA_W(DATA_W)) u_cs01 (
      .a(win_q[0]), .b(win_q[1]), .lo(lo_01), .hi(hi_01));
   trimmed_mean5_filter_cmp_swap #(.DATA_W(DATA_W)) u_cs23 (
      .a(win_q[2]), .b(win_q[3]), .lo(lo_23), .hi(hi_23));
   trimmed_mean5_filter_cmp_swap #(.DATA_W(DATA_W)) u_cs12 (
      .a(win_q[1]), .b(win_q[2]), .lo(lo_12), .hi(hi_12));
   trimmed_mean5_filter_cmp_swap #(.DATA_W(DATA_W)) u_cs34 (
      .a(win_q[3]), .b(win_q[4]), .lo(lo_34), .hi(hi_34));

   assign sum     = SUM_W'(win_q[1]) + SUM_W'(win_q[2]) + SUM_W'(win_q[3]);
   assign product = PROD_W'(sum) * PROD_W'(DIV3_MUL);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      phase_d     = phase_q;
      win_d       = win_q;
      out_valid_d = 1'b0;
      mid1_d      = mid1_q;
      mid2_d      = mid2_q;
      mid3_d      = mid3_q;
      mean_d      = mean_q;
      dropped_d   = sample_valid && (state_q != ST_COLLECT);

      case (state_q)
         ST_COLLECT: begin
            if (sample_valid) begin
               win_d[count_q] = sample;
               if (count_q == LAST_SLOT) begin
                  count_d = 3'd0;
                  phase_d = 3'd0;
                  state_d = ST_SORT;
               end else begin
                  count_d = count_q + 3'd1;
               end
            end
         end
         ST_SORT: begin
            if (!phase_q[0]) begin
               win_d[0] = lo_01;
               win_d[1] = hi_01;
               win_d[2] = lo_23;
               win_d[3] = hi_23;
            end else begin
               win_d[1] = lo_12;
               win_d[2] = hi_12;
               win_d[3] = lo_34;
               win_d[4] = hi_34;
            end
            if (phase_q == LAST_PHASE) begin
               phase_d = 3'd0;
               state_d = ST_OUTPUT;
            end else begin
               phase_d = phase_q + 3'd1;
            end
         end
         ST_OUTPUT: begin
            mid1_d      = win_q[1];
            mid2_d      = win_q[2];
            mid3_d      = win_q[3];
            mean_d      = DATA_W'(product >> DIV3_SHIFT);
            out_valid_d = 1'b1;
            state_d     = ST_COLLECT;
         end
         default: begin
            state_d = ST_COLLECT;
         end
      endcase

      // Registered busy tracks the state being entered so it matches SORT/OUTPUT exactly
      busy_d = (state_d != ST_COLLECT);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_COLLECT;
         count_q     <= 3'd0;
         phase_q     <= 3'd0;
         for (int i = 0; i < 5; i++) win_q[i] <= '0;
         busy_q      <= 1'b0;
         dropped_q   <= 1'b0;
         out_valid_q <= 1'b0;
         mid1_q      <= '0;
         mid2_q      <= '0;
         mid3_q      <= '0;
         mean_q      <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         phase_q     <= phase_d;
         win_q       <= win_d;
         busy_q      <= busy_d;
         dropped_q   <= dropped_d;
         out_valid_q <= out_valid_d;
         mid1_q      <= mid1_d;
         mid2_q      <= mid2_d;
         mid3_q      <= mid3_d;
         mean_q      <= mean_d;
      end
   end

   assign busy      = busy_q;
   assign dropped   = dropped_q;
   assign out_valid = out_valid_q;
   assign mid1      = mid1_q;
   assign mid2      = mid2_q;
   assign mid3      = mid3_q;
   assign mean      = mean_q;

endmodule

// File: tb/tb_trimmed_mean5_filter.sv
// Directed bench for trimmed_mean5_filter: each scenario task feeds a group
// and compares latency, mids and mean against hand-computed values.
module tb_trimmed_mean5_filter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sample_valid = 1'b0;
   logic [7:0] sample = 8'd0;
   logic       busy;
   logic       dropped;
   logic       out_valid;
   logic [7:0] mid1;
   logic [7:0] mid2;
   logic [7:0] mid3;
   logic [7:0] mean;

   int errors = 0;
   int checks = 0;

   trimmed_mean5_filter #(.DATA_W(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample       (sample),
      .busy         (busy),
      .dropped      (dropped),
      .out_valid    (out_valid),
      .mid1         (mid1),
      .mid2         (mid2),
      .mid3         (mid3),
      .mean         (mean)
   );

   always #5 clock = ~clock;

   // Offer one sample for a single edge, then idle for gap cycles
   task automatic feed(input logic [7:0] v, input int gap);
      sample_valid = 1'b1;
      sample       = v;
      @(posedge clock); #1;
      sample_valid = 1'b0;
      repeat (gap) begin
         @(posedge clock); #1;
      end
   endtask

   // Edges counted from the 5th accepted sample; -1 if out_valid never shows
   task automatic wait_result(output int lat);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clock); #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int lat;
      reset = 1'b1;
      repeat (2) begin
         @(posedge clock); #1;
      end
      checks++;
      if ({busy, dropped, out_valid, mid1, mid2, mid3, mean} !== 35'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {busy, dropped, out_valid, mid1, mid2, mid3, mean});
      end
      reset = 1'b0;
      @(posedge clock); #1;
      lat = 0;
   endtask

   task automatic test_back_to_back();
      int lat;
      feed(8'd1, 0); feed(8'd2, 0); feed(8'd3, 0); feed(8'd4, 0); feed(8'd5, 0);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_busy: got %b expected 1", busy);
      end
      wait_result(lat);
      checks++;
      if (lat !== 6) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 6", lat); end
      checks++;
      if (mid1 !== 8'd2) begin errors++; $display("[TB] FAIL b2b_mid1: got %0d expected 2", mid1); end
      checks++;
      if (mid2 !== 8'd3) begin errors++; $display("[TB] FAIL b2b_mid2: got %0d expected 3", mid2); end
      checks++;
      if (mid3 !== 8'd4) begin errors++; $display("[TB] FAIL b2b_mid3: got %0d expected 4", mid3); end
      checks++;
      if (mean !== 8'd3) begin errors++; $display("[TB] FAIL b2b_mean: got %0d expected 3", mean); end
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_valid_pulse: got %b expected 0", out_valid);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_busy_clear: got %b expected 0", busy);
      end
   endtask

   task automatic test_idle_gaps();
      int lat;
      feed(8'd5, 2); feed(8'd4, 2); feed(8'd3, 2); feed(8'd2, 2); feed(8'd1, 0);
      wait_result(lat);
      checks++;
      if (lat !== 6) begin errors++; $display("[TB] FAIL gaps_latency: got %0d expected 6", lat); end
      checks++;
      if (mid1 !== 8'd2) begin errors++; $display("[TB] FAIL gaps_mid1: got %0d expected 2", mid1); end
      checks++;
      if (mid2 !== 8'd3) begin errors++; $display("[TB] FAIL gaps_mid2: got %0d expected 3", mid2); end
      checks++;
      if (mid3 !== 8'd4) begin errors++; $display("[TB] FAIL gaps_mid3: got %0d expected 4", mid3); end
      checks++;
      if (mean !== 8'd3) begin errors++; $display("[TB] FAIL gaps_mean: got %0d expected 3", mean); end
      @(posedge clock); #1;
   endtask

   task automatic test_saturated();
      int lat;
      feed(8'd255, 0); feed(8'd255, 0); feed(8'd255, 0); feed(8'd0, 0); feed(8'd0, 0);
      wait_result(lat);
      checks++;
      if (lat !== 6) begin errors++; $display("[TB] FAIL sat_latency: got %0d expected 6", lat); end
      checks++;
      if (mid1 !== 8'd0) begin errors++; $display("[TB] FAIL sat_mid1: got %0d expected 0", mid1); end
      checks++;
      if (mid2 !== 8'd255) begin errors++; $display("[TB] FAIL sat_mid2: got %0d expected 255", mid2); end
      checks++;
      if (mid3 !== 8'd255) begin errors++; $display("[TB] FAIL sat_mid3: got %0d expected 255", mid3); end
      checks++;
      if (mean !== 8'd170) begin errors++; $display("[TB] FAIL sat_mean: got %0d expected 170", mean); end
      @(posedge clock); #1;
   endtask

   task automatic test_div3_edge();
      int lat;
      feed(8'd254, 0); feed(8'd255, 0); feed(8'd255, 0); feed(8'd255, 0); feed(8'd0, 0);
      wait_result(lat);
      checks++;
      if (lat !== 6) begin errors++; $display("[TB] FAIL div3_latency: got %0d expected 6", lat); end
      checks++;
      if (mid1 !== 8'd254) begin errors++; $display("[TB] FAIL div3_mid1: got %0d expected 254", mid1); end
      checks++;
      if (mid2 !== 8'd255) begin errors++; $display("[TB] FAIL div3_mid2: got %0d expected 255", mid2); end
      checks++;
      if (mid3 !== 8'd255) begin errors++; $display("[TB] FAIL div3_mid3: got %0d expected 255", mid3); end
      checks++;
      if (mean !== 8'd254) begin errors++; $display("[TB] FAIL div3_mean: got %0d expected 254", mean); end
      @(posedge clock); #1;
   endtask

   // Continuous offer of 10..23: 15..20 land in SORT/OUTPUT, 21..23 seed the next group
   task automatic test_back_to_back_overrun();
      int drop_count;
      int seen_at;
      logic [7:0] r1, r2, r3, rm;
      drop_count = 0;
      seen_at    = -1;
      r1 = 8'd0; r2 = 8'd0; r3 = 8'd0; rm = 8'd0;
      for (int i = 0; i < 14; i++) begin
         sample_valid = 1'b1;
         sample       = 8'(10 + i);
         @(posedge clock); #1;
         drop_count += int'(dropped);
         if (out_valid) begin
            seen_at = i;
            r1 = mid1; r2 = mid2; r3 = mid3; rm = mean;
         end
         if (i == 4) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ovr_busy_set: got %b expected 1", busy); end
         end
         if (i == 10) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ovr_busy_clear: got %b expected 0", busy); end
         end
      end
      sample_valid = 1'b0;
      @(posedge clock); #1;
      drop_count += int'(dropped);
      checks++;
      if (drop_count !== 6) begin errors++; $display("[TB] FAIL ovr_drop_count: got %0d expected 6", drop_count); end
      checks++;
      if (seen_at !== 10) begin errors++; $display("[TB] FAIL ovr_valid_cycle: got %0d expected 10", seen_at); end
      checks++;
      if (r1 !== 8'd11) begin errors++; $display("[TB] FAIL ovr_mid1: got %0d expected 11", r1); end
      checks++;
      if (r2 !== 8'd12) begin errors++; $display("[TB] FAIL ovr_mid2: got %0d expected 12", r2); end
      checks++;
      if (r3 !== 8'd13) begin errors++; $display("[TB] FAIL ovr_mid3: got %0d expected 13", r3); end
      checks++;
      if (rm !== 8'd12) begin errors++; $display("[TB] FAIL ovr_mean: got %0d expected 12", rm); end
   endtask

   // Completes the 21,22,23 group, resets at sort phase 2, then runs a clean group
   task automatic test_reset_mid_sort();
      int lat;
      feed(8'd24, 0); feed(8'd25, 0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if ({busy, dropped, out_valid, mid1, mid2, mid3, mean} !== 35'd0) begin
         errors++;
         $display("[TB] FAIL rst_sort_outputs: got %h expected 0",
                  {busy, dropped, out_valid, mid1, mid2, mid3, mean});
      end
      reset = 1'b0;
      @(posedge clock); #1;
      feed(8'd9, 0); feed(8'd7, 0); feed(8'd8, 0); feed(8'd6, 0); feed(8'd5, 0);
      wait_result(lat);
      checks++;
      if (lat !== 6) begin errors++; $display("[TB] FAIL rst_latency: got %0d expected 6", lat); end
      checks++;
      if (mid1 !== 8'd6) begin errors++; $display("[TB] FAIL rst_mid1: got %0d expected 6", mid1); end
      checks++;
      if (mid2 !== 8'd7) begin errors++; $display("[TB] FAIL rst_mid2: got %0d expected 7", mid2); end
      checks++;
      if (mid3 !== 8'd8) begin errors++; $display("[TB] FAIL rst_mid3: got %0d expected 8", mid3); end
      checks++;
      if (mean !== 8'd7) begin errors++; $display("[TB] FAIL rst_mean: got %0d expected 7", mean); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_idle_gaps();
      test_saturated();
      test_div3_edge();
      test_back_to_back_overrun();
      test_reset_mid_sort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
